nn_pattern_sweeper: RTL
=======================

# nn_pattern_sweeper

Parametrised stimulus/capture sequencer for the mine-detecting neural net. It replaces hand-toggled switch inputs with a clocked engine that drives the net's N_IN inputs through every pattern (or one manual pattern), holds each for a programmable dwell, and samples the net's N_OUT indicators. Each pattern/result pair is streamed out on a valid/ready port, and detections are counted. It sits between the board-level control (start/mode) and the combinational net instance.

## Interface
Parameters:
- N_IN, 4, number of net inputs (switches); 1..16
- N_OUT, 2, number of net outputs (indicators); 1..8
- DWELL, 10, cycles each pattern is held before sampling; ≥2

Ports:
- clk  in  1  clock; the single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a run; ignored unless idle
- abort  in  1  synchronous cancel of a run in progress
- mode  in  1  0 = exhaustive sweep, 1 = single manual pattern; latched at start
- manual_pat  in  N_IN  pattern applied in manual mode; latched at start
- net_in  out  N_IN  drive to net inputs
- net_out  in  N_OUT  net indicator outputs
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_pat  out  N_IN  pattern the result belongs to
- res_out  out  N_OUT  sampled net_out
- hits  out  N_IN+1  count of accepted results with res_out[0]=1
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at normal run completion

## Operation
- States: IDLE, APPLY, EMIT, DONE.
- IDLE:
  - net_in=0, res_valid=0.
  - start=1 → latch mode; load pattern = 0 (sweep) or manual_pat (manual); clear hits and dwell counter; go to APPLY.
- APPLY:
  - net_in=pattern; dwell counter increments.
  - At count DWELL-1: register res_pat=pattern, res_out=net_out, set res_valid, go to EMIT.
- EMIT:
  - net_in stays at pattern; res_valid/res_pat/res_out held stable until res_valid&&res_ready.
  - On handshake: hits += res_out[0]; res_valid cleared.
  - Manual mode, or pattern all-ones → DONE.
  - Otherwise pattern+1, dwell counter=0, go to APPLY.
- DONE: done=1 for this cycle only; next state IDLE.
- Pattern never wraps: all-ones is the terminal sweep pattern. hits saturates by construction; max 2^N_IN fits in N_IN+1 bits.
- hits, res_pat and res_out hold their last values in IDLE until the next start.
- start while busy: ignored, no effect on latched mode or pattern.
- abort=1 in any non-IDLE state → IDLE next cycle.
  - No done pulse; res_valid drops; hits retains its partial count.
  - abort takes precedence over a same-cycle handshake; that result is not counted.
- start and abort together in IDLE: abort wins, stay IDLE.
- rst_n=0 (any state, mid-run included): next edge gives state=IDLE, net_in=0, res_valid=0, res_pat=0, res_out=0, hits=0, busy=0, done=0, dwell counter=0.

## Timing
- start sampled at edge E0 → APPLY cycles 1..DWELL, net_in valid from cycle 1.
- net_out sampled at the edge ending cycle DWELL → res_valid high from cycle DWELL+1.
- With res_ready held high: each pattern costs DWELL+1 cycles.
  - Full sweep: done in cycle 2^N_IN·(DWELL+1)+1; busy low the cycle after.
  - Manual run: done in cycle DWELL+2.
- res_ready low stalls the sweep indefinitely; net_in stays at the current pattern throughout.
- All outputs registered or state-decoded; no combinational path from inputs to outputs.

## Structure
- Shared package nn_ctrl_pkg:
  - state encoding localparams (IDLE=0, APPLY=1, EMIT=2, DONE=3);
  - default N_IN/N_OUT, also used by the net controller.
- Sub-module nn_dwell_timer: width $clog2(DWELL) counter with clear/enable and a terminal-count flag.
- Top-level FSM, pattern register and hit counter live in nn_pattern_sweeper.

## Test plan
- Sweep, N_IN=4, DWELL=10, res_ready=1, net model flags mine only for 4'b1011 → 16 results in order 0..15, only res_pat=11 has res_out[0]=1; hits=1; done in cycle 177.
- Manual mode, manual_pat=4'b0110, DWELL=10 → exactly one result, res_pat=6; done in cycle 12; start during the run is ignored.
- Backpressure: res_ready low for 5 cycles at pattern 3 → res_valid/res_pat=3/net_in=3 stable for the stall; pattern 4 applied the cycle after acceptance.
- abort in APPLY at pattern 7 → IDLE next cycle, net_in=0, no done pulse, hits = detections on patterns 0..6.
- rst_n low mid-EMIT → all outputs at reset values next cycle; a subsequent start runs a clean full sweep.
- start and abort asserted together in IDLE → remains IDLE, busy=0.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the mine-net stimulus and control blocks.
// Provides the sequencer state encoding and default net dimensions.
package nn_ctrl_pkg;

    localparam int N_IN_DEF  = 4;
    localparam int N_OUT_DEF = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        APPLY = ST_APPLY,
        EMIT  = ST_EMIT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/nn_dwell_timer.sv
// Dwell counter: counts enabled cycles from zero and flags DWELL-1.
// Ports: clk, rst_n (sync, active-low), clear, enable, tc (terminal count).
module nn_dwell_timer #(
    parameter int DWELL = 10,
    localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [W-1:0] count;

    // Parks at terminal count so a power-of-two DWELL never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(DWELL - 1));

endmodule

// File: rtl/nn_pattern_sweeper.sv
// Drives the mine net through all input patterns (or one manual pattern),
// holds each for DWELL cycles, samples net_out and streams pattern/result
// pairs on a valid/ready port while counting detections (res_out[0]).
// Ports: clk, rst_n, start, abort, mode, manual_pat | net_in, net_out |
//        res_valid, res_ready, res_pat, res_out | hits, busy, done.
module nn_pattern_sweeper
    import nn_ctrl_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int DWELL = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [N_IN-1:0]  manual_pat,
    output logic [N_IN-1:0]  net_in,
    input  logic [N_OUT-1:0] net_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N_IN-1:0]  res_pat,
    output logic [N_OUT-1:0] res_out,
    output logic [N_IN:0]    hits,
    output logic             busy,
    output logic             done
);

    state_t          state;
    logic            mode_q;
    logic [N_IN-1:0] pattern;
    logic            tc;
    logic            timer_clr;
    logic            timer_en;

    // Counter runs only in APPLY and is zero on every entry to APPLY.
    assign timer_clr = (state != APPLY);
    assign timer_en  = (state == APPLY);

    nn_dwell_timer #(
        .DWELL(DWELL)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clr),
        .enable(timer_en),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            pattern <= '0;
            res_pat <= '0;
            res_out <= '0;
            hits    <= '0;
        end else if (abort) begin
            // Beats start in IDLE and a same-cycle handshake in EMIT.
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        pattern <= mode ? manual_pat : '0;
                        hits    <= '0;
                        state   <= APPLY;
                    end
                end
                APPLY: begin
                    if (tc) begin
                        res_pat <= pattern;
                        res_out <= net_out;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        hits <= hits + (N_IN + 1)'(res_out[0]);
                        // All-ones is terminal, so pattern never wraps.
                        if (mode_q || (&pattern)) begin
                            state <= DONE;
                        end else begin
                            pattern <= pattern + 1'b1;
                            state   <= APPLY;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign res_valid = (state == EMIT);
    assign net_in    = ((state == APPLY) || (state == EMIT)) ? pattern : '0;

endmodule
